// File: rtl/jtag_dbgreg_ctrl_if.sv
// Output stream of the JTAG debug register controller.
// The controller (master) presents a completed DR word together with the
// register it came from; the consumer (slave) accepts it with out_ready.
interface jtag_dbgreg_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_sel,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_sel,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/jtag_dbgreg_ctrl.sv
// JTAG debug data register controller.
// Brings the raw JTAGG primitive signals into the clk domain, detects rising
// TCK edges and runs a capture/shift/update DR state machine. Completed words
// of the correct length are handed out through a one-entry valid/ready buffer.
// Short or long words raise len_err; words arriving while the buffer is full
// raise ovf.
module jtag_dbgreg_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 jtck,
    input  logic                 jtdi,
    input  logic                 jshift,
    input  logic                 jupdate,
    input  logic                 jce1,
    input  logic                 jce2,
    input  logic                 jrstn,
    output logic                 jtdo1,
    output logic                 jtdo2,
    input  logic [WIDTH-1:0]     rd_data,
    output logic                 ovf,
    output logic                 len_err,
    input  logic                 clr_flags,
    jtag_dbgreg_ctrl_if.master   out_if
);

    localparam int NSYNC = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][NSYNC-1:0] sync_q;
    logic [NSYNC-1:0]                  jtag_raw;
    logic [NSYNC-1:0]                  jtag_s;
    logic                              tck_d;

    logic tck_s, tdi_s, shift_s, update_s, ce1_s, ce2_s, jrstn_s;
    logic tck_ev;

    state_t state, state_next;
    logic   do_capture, do_shift, do_update;

    logic [WIDTH-1:0] shreg;
    logic [5:0]       bitcnt;
    logic             sel;

    logic [WIDTH-1:0] out_data_q;
    logic             out_sel_q;
    logic             out_valid_q;

    logic len_ok, buf_free, load_word, drop_ovf, drop_len;

    assign jtag_raw = {jrstn, jce2, jce1, jupdate, jshift, jtdi, jtck};
    assign jtag_s   = sync_q[SYNC_STAGES-1];

    assign tck_s    = jtag_s[0];
    assign tdi_s    = jtag_s[1];
    assign shift_s  = jtag_s[2];
    assign update_s = jtag_s[3];
    assign ce1_s    = jtag_s[4];
    assign ce2_s    = jtag_s[5];
    assign jrstn_s  = jtag_s[6];

    // One cycle wide pulse on each rising TCK edge seen in the clk domain.
    assign tck_ev = tck_s & ~tck_d;

    // Synchronise all JTAG signals together and keep one extra TCK copy for edge detect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            tck_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], jtag_raw};
            tck_d  <= tck_s;
        end
    end

    // DR state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the datapath strobes for capture, shift and update.
    always_comb begin
        state_next = state;
        do_capture = 1'b0;
        do_shift   = 1'b0;
        do_update  = 1'b0;
        if (!jrstn_s) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (tck_ev && (ce1_s || ce2_s)) begin
                        do_capture = 1'b1;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (tck_ev) begin
                        if (update_s) begin
                            state_next = UPDATE;
                        end else if (shift_s) begin
                            do_shift = 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    do_update  = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Shift register, bit counter and register select; a JTAG-side reset clears the shift state only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg  <= '0;
            bitcnt <= '0;
            sel    <= 1'b0;
        end else if (!jrstn_s) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (do_capture) begin
            shreg  <= rd_data;
            sel    <= ce2_s;
            bitcnt <= '0;
        end else if (do_shift) begin
            shreg <= {tdi_s, shreg[WIDTH-1:1]};
            if (bitcnt != 6'd63) begin
                bitcnt <= bitcnt + 6'd1;
            end
        end
    end

    assign len_ok    = (bitcnt == 6'(WIDTH));
    assign buf_free  = ~out_valid_q | out_if.out_ready;
    assign load_word = do_update & len_ok & buf_free;
    assign drop_ovf  = do_update & len_ok & ~buf_free;
    assign drop_len  = do_update & ~len_ok;

    // One-entry output buffer; a load in the same cycle as a transfer keeps valid high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (load_word) begin
            out_data_q  <= shreg;
            out_sel_q   <= sel;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && out_if.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes precedence.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf     <= 1'b0;
            len_err <= 1'b0;
        end else begin
            if (drop_ovf) begin
                ovf <= 1'b1;
            end else if (clr_flags) begin
                ovf <= 1'b0;
            end
            if (drop_len) begin
                len_err <= 1'b1;
            end else if (clr_flags) begin
                len_err <= 1'b0;
            end
        end
    end

    // Registered TDO bits, each gated to the register currently selected.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            jtdo1 <= 1'b0;
            jtdo2 <= 1'b0;
        end else begin
            jtdo1 <= ~sel & shreg[0];
            jtdo2 <= sel & shreg[0];
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_sel   = out_sel_q;
    assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_jtag_dbgreg_ctrl.sv
// Directed bench for jtag_dbgreg_ctrl: drives JTAG DR sequences slowly
// relative to clk and checks delivered words, flags and TDO streams.
module tb_jtag_dbgreg_ctrl;

    localparam int WIDTH = 32;

    logic             clk       = 1'b0;
    logic             rstn      = 1'b0;
    logic             jtck      = 1'b0;
    logic             jtdi      = 1'b0;
    logic             jshift    = 1'b0;
    logic             jupdate   = 1'b0;
    logic             jce1      = 1'b0;
    logic             jce2      = 1'b0;
    logic             jrstn     = 1'b1;
    logic             jtdo1;
    logic             jtdo2;
    logic [WIDTH-1:0] rd_data   = '0;
    logic             ovf;
    logic             len_err;
    logic             clr_flags = 1'b0;

    int cmp_cnt = 0;
    int err_cnt = 0;

    jtag_dbgreg_ctrl_if #(.WIDTH(WIDTH)) out_if ();

    jtag_dbgreg_ctrl #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .jtck      (jtck),
        .jtdi      (jtdi),
        .jshift    (jshift),
        .jupdate   (jupdate),
        .jce1      (jce1),
        .jce2      (jce2),
        .jrstn     (jrstn),
        .jtdo1     (jtdo1),
        .jtdo2     (jtdo2),
        .rd_data   (rd_data),
        .ovf       (ovf),
        .len_err   (len_err),
        .clr_flags (clr_flags),
        .out_if    (out_if.master)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One TCK period: set inputs with TCK low, sample TDO, then raise TCK.
    task automatic apply_stimulus(input logic ce1, input logic ce2, input logic sh,
                                  input logic upd, input logic tdi,
                                  output logic t1, output logic t2);
        jtck    = 1'b0;
        jce1    = ce1;
        jce2    = ce2;
        jshift  = sh;
        jupdate = upd;
        jtdi    = tdi;
        repeat (4) @(negedge clk);
        t1   = jtdo1;
        t2   = jtdo2;
        jtck = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Capture, shift nbits of wdata LSB first, then exit (no update).
    task automatic run_sequence(input logic er2, input logic [31:0] rd, input logic [31:0] wdata,
                                input int nbits, output logic [31:0] tdo1_word,
                                output logic [31:0] tdo2_word);
        logic t1, t2;
        rd_data = rd;
        apply_stimulus(~er2, er2, 1'b0, 1'b0, 1'b0, t1, t2);
        tdo1_word = '0;
        tdo2_word = '0;
        for (int i = 0; i < nbits; i++) begin
            apply_stimulus(~er2, er2, 1'b1, 1'b0, wdata[i], t1, t2);
            tdo1_word[i] = t1;
            tdo2_word[i] = t2;
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t1, t2);
    endtask

    // Update TCK edge, then watch out_valid for 12 cycles after TCK rises.
    task automatic update_watch(output int first_hi, output int hi_cnt,
                                output logic [31:0] data_seen, output logic sel_seen);
        jtck    = 1'b0;
        jce1    = 1'b0;
        jce2    = 1'b0;
        jshift  = 1'b0;
        jupdate = 1'b1;
        repeat (4) @(negedge clk);
        jtck      = 1'b1;
        first_hi  = -1;
        hi_cnt    = 0;
        data_seen = '0;
        sel_seen  = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (out_if.out_valid) begin
                if (first_hi < 0) begin
                    first_hi  = k;
                    data_seen = out_if.out_data;
                    sel_seen  = out_if.out_sel;
                end
                hi_cnt++;
            end
        end
        jupdate = 1'b0;
    endtask

    task automatic consume_word();
        out_if.out_ready = 1'b1;
        @(negedge clk);
        out_if.out_ready = 1'b0;
        @(negedge clk);
    endtask

    // Directed test sequence.
    initial begin
        logic [31:0] w1, w2, dseen;
        logic        sseen, t1, t2;
        int          first_hi, hi_cnt;

        out_if.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_output("rst_valid", 32'(out_if.out_valid), 32'd0);
        check_output("rst_data", out_if.out_data, 32'd0);
        check_output("rst_flags", {30'd0, ovf, len_err}, 32'd0);
        check_output("rst_tdo", {30'd0, jtdo1, jtdo2}, 32'd0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // ER1 capture/shift/update, latency and TDO stream
        $display("[TB] ER1 basic sequence");
        run_sequence(1'b0, 32'hCAFE_F00D, 32'h1234_5678, 32, w1, w2);
        update_watch(first_hi, hi_cnt, dseen, sseen);
        check_output("er1_latency", 32'(first_hi), 32'd4);
        check_output("er1_data", dseen, 32'h1234_5678);
        check_output("er1_sel", 32'(sseen), 32'd0);
        check_output("er1_tdo1", w1, 32'hCAFE_F00D);
        check_output("er1_tdo2", w2, 32'd0);
        check_output("er1_flags", {30'd0, ovf, len_err}, 32'd0);
        consume_word();
        check_output("er1_drained", 32'(out_if.out_valid), 32'd0);

        // ER2 with consumer always ready
        $display("[TB] ER2 with out_ready high");
        run_sequence(1'b1, 32'h0F1E_2D3C, 32'hA5A5_5A5A, 32, w1, w2);
        out_if.out_ready = 1'b1;
        update_watch(first_hi, hi_cnt, dseen, sseen);
        out_if.out_ready = 1'b0;
        check_output("er2_hi_cycles", 32'(hi_cnt), 32'd1);
        check_output("er2_data", dseen, 32'hA5A5_5A5A);
        check_output("er2_sel", 32'(sseen), 32'd1);
        check_output("er2_ovf", 32'(ovf), 32'd0);
        check_output("er2_tdo2", w2, 32'h0F1E_2D3C);
        check_output("er2_tdo1", w1, 32'd0);

        // Overflow: two words with nobody consuming
        $display("[TB] overflow");
        run_sequence(1'b0, 32'd0, 32'h1111_1111, 32, w1, w2);
        update_watch(first_hi, hi_cnt, dseen, sseen);
        check_output("ovf_first_data", dseen, 32'h1111_1111);
        check_output("ovf_first_flag", 32'(ovf), 32'd0);
        run_sequence(1'b1, 32'd0, 32'h2222_2222, 32, w1, w2);
        update_watch(first_hi, hi_cnt, dseen, sseen);
        check_output("ovf_retained", out_if.out_data, 32'h1111_1111);
        check_output("ovf_retained_sel", 32'(out_if.out_sel), 32'd0);
        check_output("ovf_set", 32'(ovf), 32'd1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        @(negedge clk);
        check_output("ovf_cleared", 32'(ovf), 32'd0);
        consume_word();
        check_output("ovf_drained", 32'(out_if.out_valid), 32'd0);

        // Short word: 31 bits
        $display("[TB] length error");
        run_sequence(1'b0, 32'd0, 32'h0F0F_0F0F, 31, w1, w2);
        update_watch(first_hi, hi_cnt, dseen, sseen);
        check_output("len_no_valid", 32'(hi_cnt), 32'd0);
        check_output("len_err_set", 32'(len_err), 32'd1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        @(negedge clk);
        check_output("len_err_cleared", 32'(len_err), 32'd0);

        // JTAG reset mid-shift, then a full word
        $display("[TB] jrstn mid-shift");
        rd_data = 32'hFFFF_FFFF;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, t1, t2);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t1, t2);
        end
        check_output("jrst_pre_tdo1", 32'(jtdo1), 32'd1);
        jrstn = 1'b0;
        repeat (6) @(negedge clk);
        check_output("jrst_tdo1_cleared", 32'(jtdo1), 32'd0);
        jrstn = 1'b1;
        repeat (6) @(negedge clk);
        run_sequence(1'b0, 32'd0, 32'h8765_4321, 32, w1, w2);
        update_watch(first_hi, hi_cnt, dseen, sseen);
        check_output("jrst_data", dseen, 32'h8765_4321);
        check_output("jrst_sel", 32'(sseen), 32'd0);
        check_output("jrst_len_err", 32'(len_err), 32'd0);
        consume_word();

        // System reset mid-shift with a word pending
        $display("[TB] rstn mid-shift");
        run_sequence(1'b0, 32'd0, 32'h1357_2468, 32, w1, w2);
        update_watch(first_hi, hi_cnt, dseen, sseen);
        check_output("rst2_pending", 32'(out_if.out_valid), 32'd1);
        rd_data = 32'hFFFF_FFFF;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, t1, t2);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, t1, t2);
        end
        jtck   = 1'b0;
        jce1   = 1'b0;
        jshift = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst2_pre_tdo1", 32'(jtdo1), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_output("rst2_valid", 32'(out_if.out_valid), 32'd0);
        check_output("rst2_data", out_if.out_data, 32'd0);
        check_output("rst2_tdo", {30'd0, jtdo1, jtdo2}, 32'd0);
        check_output("rst2_sel_flags", {29'd0, out_if.out_sel, ovf, len_err}, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        run_sequence(1'b1, 32'd0, 32'h2468_ACE0, 32, w1, w2);
        update_watch(first_hi, hi_cnt, dseen, sseen);
        check_output("rst2_after_data", dseen, 32'h2468_ACE0);
        check_output("rst2_after_sel", 32'(sseen), 32'd1);
        check_output("rst2_after_latency", 32'(first_hi), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
